// File: rtl/bytecode_sequencer_pkg.sv
// Shared definitions for the bytecode fetch/execute sequencer.
//   state_t     : sequencer FSM states (also exported on the debug port)
//   OP_*RETURN  : method-return opcodes; fetching any of them halts execution
//   is_return_op: true for any of the three return opcodes
package bytecode_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_LATCH   = 4'd2,
        ST_DECODE  = 4'd3,
        ST_ARG_RD  = 4'd4,
        ST_ARG_CAP = 4'd5,
        ST_POP     = 4'd6,
        ST_EXEC    = 4'd7,
        ST_WAIT    = 4'd8,
        ST_PUSH    = 4'd9,
        ST_NEXT    = 4'd10,
        ST_HALT    = 4'd11
    } state_t;

    localparam logic [7:0] OP_IRETURN = 8'hAC;
    localparam logic [7:0] OP_ARETURN = 8'hB0;
    localparam logic [7:0] OP_RETURN  = 8'hB1;

    function automatic logic is_return_op(input logic [7:0] op);
        return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
    endfunction

endpackage

// File: rtl/bytecode_sequencer_arg_collector.sv
// Argument byte collector for the bytecode sequencer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : clears the shift register and byte counter
//   i_shift    : shifts i_byte into the low byte and counts it
//   i_byte     : program memory byte being captured
//   i_argc     : number of argument bytes of the current instruction
//   o_arg      : collected argument (first byte ends up in [15:8] for argc=2)
//   o_last     : the byte being shifted this cycle is the final one
//   o_offset   : branch offset, sign-extended from 8 or 16 bits by argc,
//                truncated/extended to OFF_WIDTH
module bytecode_sequencer_arg_collector #(
    parameter int OFF_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_shift,
    input  logic [7:0]           i_byte,
    input  logic [1:0]           i_argc,
    output logic [15:0]          o_arg,
    output logic                 o_last,
    output logic [OFF_WIDTH-1:0] o_offset
);

    logic [15:0] r_arg;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arg <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_arg <= '0;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_arg <= {r_arg[7:0], i_byte};
            r_cnt <= w_cnt_next;
        end
    end

    assign w_cnt_next = r_cnt + 2'd1;
    assign o_last     = (w_cnt_next == i_argc);
    assign o_arg      = r_arg;

    // A one-byte argument is a signed 8-bit offset; otherwise the full 16 bits.
    always_comb begin
        if (i_argc == 2'd1) begin
            o_offset = OFF_WIDTH'($signed(r_arg[7:0]));
        end else begin
            o_offset = OFF_WIDTH'($signed(r_arg));
        end
    end

endmodule

// File: rtl/bytecode_sequencer.sv
// Multi-cycle fetch/execute controller for the bytecode core.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : level; begins execution at PC 0 from IDLE/HALT
//   prog_rd/prog_addr   : program memory read strobe and byte address
//   prog_data           : read data, valid the cycle after prog_rd
//   opcode              : latched opcode to the external decoder
//   argc..iscmp         : decoder outputs for the latched opcode
//   cmp_true            : comparator result, valid with exec_done
//   arg                 : collected argument bytes
//   stack_pop/exec/stack_push : one-cycle datapath strobes
//   exec_done           : datapath completion, sampled only in WAIT
//   busy/done           : running / halted
//   dbg_state           : current FSM state
// Handshake: exec is a single-cycle request; the sequencer then waits in
// WAIT until the datapath raises exec_done, which is ignored in every
// other state.
module bytecode_sequencer
    import bytecode_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                prog_rd,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [7:0]          prog_data,
    output logic [7:0]          opcode,
    input  logic [1:0]          argc,
    input  logic [1:0]          stackargs,
    input  logic                stackwb,
    input  logic                isgoto,
    input  logic                iscmp,
    input  logic                cmp_true,
    output logic [15:0]         arg,
    output logic                stack_pop,
    output logic                exec,
    input  logic                exec_done,
    output logic                stack_push,
    output logic                busy,
    output logic                done,
    output state_t              dbg_state
);

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_ipc;
    logic [7:0]          r_opcode;
    logic [1:0]          r_argc;
    logic [1:0]          r_stackargs;
    logic                r_stackwb;
    logic                r_isgoto;
    logic                r_iscmp;
    logic                r_cmp;
    logic [1:0]          r_pop_cnt;
    logic                w_pop_last;
    logic                w_arg_last;
    logic                w_take_branch;
    logic [15:0]         w_arg;
    logic [PC_WIDTH-1:0] w_offset;

    bytecode_sequencer_arg_collector #(
        .OFF_WIDTH (PC_WIDTH)
    ) u_arg_collector (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state == ST_DECODE),
        .i_shift  (r_state == ST_ARG_CAP),
        .i_byte   (prog_data),
        .i_argc   (r_argc),
        .o_arg    (w_arg),
        .o_last   (w_arg_last),
        .o_offset (w_offset)
    );

    assign w_pop_last    = ((r_pop_cnt + 2'd1) == r_stackargs);
    assign w_take_branch = r_isgoto || (r_iscmp && r_cmp);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DECODE looks at the live decoder outputs because
    // they are only registered at the end of that cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: if (start) w_state_next = ST_FETCH;
            ST_FETCH:         w_state_next = ST_LATCH;
            ST_LATCH:         w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_return_op(r_opcode))  w_state_next = ST_HALT;
                else if (argc != 2'd0)       w_state_next = ST_ARG_RD;
                else if (stackargs != 2'd0)  w_state_next = ST_POP;
                else                         w_state_next = ST_EXEC;
            end
            ST_ARG_RD:        w_state_next = ST_ARG_CAP;
            ST_ARG_CAP: begin
                if (!w_arg_last)                w_state_next = ST_ARG_RD;
                else if (r_stackargs != 2'd0)   w_state_next = ST_POP;
                else                            w_state_next = ST_EXEC;
            end
            ST_POP:           if (w_pop_last) w_state_next = ST_EXEC;
            ST_EXEC:          w_state_next = ST_WAIT;
            ST_WAIT:          if (exec_done) w_state_next = r_stackwb ? ST_PUSH : ST_NEXT;
            ST_PUSH:          w_state_next = ST_NEXT;
            ST_NEXT:          w_state_next = ST_FETCH;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        prog_rd    = 1'b0;
        stack_pop  = 1'b0;
        exec       = 1'b0;
        stack_push = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (r_state)
            ST_FETCH, ST_ARG_RD: prog_rd    = 1'b1;
            ST_POP:              stack_pop  = 1'b1;
            ST_EXEC:             exec       = 1'b1;
            ST_PUSH:             stack_push = 1'b1;
            ST_IDLE:             busy       = 1'b0;
            ST_HALT: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // PC, opcode and per-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_ipc       <= '0;
            r_opcode    <= '0;
            r_argc      <= '0;
            r_stackargs <= '0;
            r_stackwb   <= 1'b0;
            r_isgoto    <= 1'b0;
            r_iscmp     <= 1'b0;
            r_cmp       <= 1'b0;
            r_pop_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: if (start) r_pc <= '0;
                ST_FETCH:         r_ipc <= r_pc;
                ST_LATCH: begin
                    r_opcode <= prog_data;
                    r_pc     <= r_pc + PC_WIDTH'(1);
                end
                ST_DECODE: begin
                    r_argc      <= argc;
                    r_stackargs <= stackargs;
                    r_stackwb   <= stackwb;
                    r_isgoto    <= isgoto;
                    r_iscmp     <= iscmp;
                    r_pop_cnt   <= '0;
                end
                ST_ARG_CAP:       r_pc <= r_pc + PC_WIDTH'(1);
                ST_POP:           r_pop_cnt <= r_pop_cnt + 2'd1;
                ST_WAIT:          if (exec_done) r_cmp <= cmp_true;
                // Branch targets are relative to the opcode's own address.
                ST_NEXT:          if (w_take_branch) r_pc <= r_ipc + w_offset;
                default: ;
            endcase
        end
    end

    assign prog_addr = r_pc;
    assign opcode    = r_opcode;
    assign arg       = w_arg;
    assign dbg_state = r_state;

endmodule
